// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the 5-stage ARM pipeline control logic.
//   REG_W          : register index width (R0..R15)
//   shadow_slot_t  : per-stage shadow of the instruction's register write info
//   seq_state_e    : pipeline sequencer FSM state encoding
// ---------------------------------------------------------------------------
package arm_pkg;

  localparam int REG_W = 4;

  // Shadow copy of what an in-flight instruction will write back.
  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             mem_r_en;
    logic [REG_W-1:0] dest;
  } shadow_slot_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational RAW hazard check of the ID instruction against the
// EXE and MEM shadow slots.
// Ports:
//   fwd_en      in  forwarding active; only load-use in EXE blocks
//   id_valid    in  ID holds a real instruction
//   id_src1     in  first source register
//   id_src2     in  second source register
//   id_two_src  in  id_src2 is a true source
//   exe_slot    in  shadow of the EXE instruction
//   mem_slot    in  shadow of the MEM instruction
//   hazard      out RAW hazard present
// ---------------------------------------------------------------------------
module hazard_detect
  import arm_pkg::*;
(
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  shadow_slot_t     exe_slot,
  input  shadow_slot_t     mem_slot,
  output logic             hazard
);

  logic hit_src1;
  logic hit_src2;

  // With forwarding, everything but a load still in EXE can be bypassed.
  // WB is never checked because the register file writes on the falling edge.
  function automatic logic slot_hit(input logic             fwd,
                                    input shadow_slot_t     exe_s,
                                    input shadow_slot_t     mem_s,
                                    input logic [REG_W-1:0] src);
    logic exe_hit;
    logic mem_hit;
    exe_hit = exe_s.valid & exe_s.wb_en & (exe_s.dest == src);
    mem_hit = mem_s.valid & mem_s.wb_en & (mem_s.dest == src);
    if (fwd) begin
      return exe_s.valid & exe_s.mem_r_en & (exe_s.dest == src);
    end
    return exe_hit | mem_hit;
  endfunction

  always_comb begin
    hit_src1 = slot_hit(fwd_en, exe_slot, mem_slot, id_src1);
    hit_src2 = slot_hit(fwd_en, exe_slot, mem_slot, id_src2);
    hazard   = id_valid & (hit_src1 | (id_two_src & hit_src2));
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
// Central stall/flush controller for the IF/ID/EXE/MEM/WB pipeline.
// Tracks EXE/MEM destination registers in shadow slots, detects RAW hazards
// against ID, applies branch flushes and freezes the pipeline during SRAM
// waits (with a sticky watchdog flag).
// Ports:
//   clk           in  clock, rising edge
//   rst           in  asynchronous active-low reset
//   fwd_en        in  forwarding unit active
//   id_*          in  ID-stage instruction info
//   branch_taken  in  branch resolved taken in EXE
//   mem_req       in  MEM stage accessing SRAM
//   mem_ready     in  SRAM access completes this cycle
//   freeze_pc     out hold PC and IF/ID
//   flush_if_id   out clear IF/ID
//   bubble_id_ex  out load NOP into ID/EX
//   freeze_all    out hold ID/EX, EX/MEM, MEM/WB
//   hazard        out RAW hazard detected
//   mem_err       out sticky SRAM timeout
// ---------------------------------------------------------------------------
module pipeline_sequencer
  import arm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             freeze_all,
  output logic             hazard,
  output logic             mem_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  shadow_slot_t     exe_slot_q, exe_slot_d;
  shadow_slot_t     mem_slot_q, mem_slot_d;
  logic             issue;

  hazard_detect u_hazard_detect (
    .fwd_en     (fwd_en),
    .id_valid   (id_valid),
    .id_src1    (id_src1),
    .id_src2    (id_src2),
    .id_two_src (id_two_src),
    .exe_slot   (exe_slot_q),
    .mem_slot   (mem_slot_q),
    .hazard     (hazard)
  );

  // The freeze comes straight from the SRAM handshake in both states: the
  // frozen EX/MEM register keeps mem_req stable for the whole wait.
  assign freeze_all   = mem_req & ~mem_ready;
  assign freeze_pc    = freeze_all | (hazard & ~branch_taken);
  assign flush_if_id  = branch_taken & ~freeze_all;
  assign bubble_id_ex = (branch_taken | hazard) & ~freeze_all;
  assign mem_err      = mem_err_q;

  // A taken branch discards the ID instruction even when it is hazard-free.
  assign issue = id_valid & ~hazard & ~branch_taken;

  // Shadow slots advance with the real pipeline registers.
  always_comb begin
    exe_slot_d = exe_slot_q;
    mem_slot_d = mem_slot_q;
    if (!freeze_all) begin
      mem_slot_d = exe_slot_q;
      if (issue) begin
        exe_slot_d.valid    = 1'b1;
        exe_slot_d.wb_en    = id_wb_en;
        exe_slot_d.mem_r_en = id_mem_r_en;
        exe_slot_d.dest     = id_dest;
      end else begin
        exe_slot_d = '0;
      end
    end
  end

  // Wait FSM and watchdog: the counter saturates at the timeout so the
  // error flag is raised exactly once and then stays set until reset.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else begin
          if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          if (wait_cnt_d == CNT_MAX) begin
            mem_err_d = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      exe_slot_q <= '0;
      mem_slot_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      exe_slot_q <= exe_slot_d;
      mem_slot_q <= mem_slot_d;
    end
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Central stall/flush controller for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Keeps its own shadow of the destination registers of the instructions in EXE and MEM, and detects RAW hazards against the instruction in ID. Result forwarding can be switched on or off.
- Applies branch flushes from EXE.
- Freezes the whole pipeline while the multi-cycle SRAM in MEM is busy, with a watchdog on that wait.
- Drives the PC and pipeline-register enables and flushes.

Parameters:
REG_W, 4, register index width (R0..R15)
MEM_TIMEOUT, 63, MEM_WAIT cycles without mem_ready before mem_err is raised

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
fwd_en  in  1  1 = forwarding unit active; only load-use hazards stall
id_valid  in  1  ID holds a real instruction
id_src1  in  REG_W  Rn of the ID instruction
id_src2  in  REG_W  Rm, or Rd for STR
id_two_src  in  1  id_src2 is a true source
id_wb_en  in  1  ID instruction writes the register file
id_mem_r_en  in  1  ID instruction is LDR
id_dest  in  REG_W  Rd of the ID instruction
branch_taken  in  1  B is resolved in EXE this cycle
mem_req  in  1  MEM stage is accessing SRAM (LDR/STR)
mem_ready  in  1  SRAM access completes this cycle
freeze_pc  out  1  hold the PC and the IF/ID register
flush_if_id  out  1  clear the IF/ID register
bubble_id_ex  out  1  load a NOP into the ID/EX register
freeze_all  out  1  hold ID/EX, EX/MEM and MEM/WB
hazard  out  1  RAW hazard detected (visibility)
mem_err  out  1  sticky SRAM timeout flag

Behaviour:
- Reset (rst=0, asynchronous): state=RUN; both shadow slots invalid; wait counter=0; mem_err=0.
  - All outputs are combinational from state and slots, so all are 0 immediately after reset with idle inputs.
  - A reset during MEM_WAIT abandons the wait.
- Shadow slots exe_s and mem_s: {valid, wb_en, mem_r_en, dest}.
- On every rising edge with freeze_all=0:
  - mem_s <= exe_s.
  - exe_s <= ID info if issue=1, else bubble (valid=0).
  - issue = id_valid & ~hazard & ~branch_taken.
- With freeze_all=1 the slots hold.
- WB stage is never checked: the register file writes on negedge, so there is no WB hazard.
- Hazard, with fwd_en=0: hit(x) = (exe_s.valid & exe_s.wb_en & exe_s.dest==x) | (mem_s.valid & mem_s.wb_en & mem_s.dest==x).
- Hazard, with fwd_en=1: hit(x) = exe_s.valid & exe_s.mem_r_en & exe_s.dest==x (load-use only).
- hazard = id_valid & (hit(id_src1) | (id_two_src & hit(id_src2))).
- FSM states RUN and MEM_WAIT:
  - RUN -> MEM_WAIT when mem_req & ~mem_ready; counter cleared.
  - MEM_WAIT -> RUN when mem_ready.
  - Otherwise MEM_WAIT stays; counter increments, saturating at MEM_TIMEOUT.
  - When the counter reaches MEM_TIMEOUT, mem_err <= 1. It is sticky until reset. The pipeline stays frozen.
  - A single-cycle access (mem_req & mem_ready in RUN) causes no freeze.
- freeze_all = mem_req & ~mem_ready. This holds in both states; mem_req is held stable by the frozen EX/MEM register.
- Output priority is memory wait > branch > hazard:
  - freeze_pc = freeze_all | (hazard & ~branch_taken)
  - flush_if_id = branch_taken & ~freeze_all
  - bubble_id_ex = (branch_taken | hazard) & ~freeze_all
- Simultaneous events:
  - Branch plus hazard: the branch wins. The PC loads the target and the ID instruction is discarded.
  - branch_taken during a freeze: ignored until the freeze releases. EXE holds the branch, so it re-presents it.
- A hazard stall lasts one cycle per blocking slot. With fwd_en=0 this is at most 2 cycles; with fwd_en=1, exactly 1 for load-use.

Decomposition:
- Shared package arm_pkg:
  - REG_W
  - shadow-slot struct {valid, wb_en, mem_r_en, dest}
  - FSM state encoding (RUN=1'b0, MEM_WAIT=1'b1)
- One sub-module, hazard_detect: purely combinational slot compare.
- FSM, counter and shadow slots stay in the top module.

Test Plan:
- Dependent ADD, fwd_en=0: ADD R1 issued, next ID src1=R1 -> hazard=1, freeze_pc=1, bubble_id_ex=1 for 2 cycles, then issue.
- LDR then dependent op, fwd_en=1: LDR R2, next ID src2=R2 with two_src=1 -> 1-cycle stall; with id_two_src=0 -> no stall.
- Branch plus hazard: branch_taken=1 with hazard=1 -> flush_if_id=1, bubble_id_ex=1, freeze_pc=0.
- SRAM wait: mem_req=1, mem_ready low for 5 cycles -> freeze_all=1 for exactly 5 cycles, slots unchanged; released in the mem_ready cycle.
- Timeout: MEM_TIMEOUT=8, mem_ready never asserted -> mem_err=1 after the 8th MEM_WAIT cycle; freeze_all stays 1.
- Reset mid-wait: rst=0 during MEM_WAIT -> freeze_all follows inputs only; after release with mem_req=0, all outputs 0 and a prior dependent ID instruction shows no hazard (slots cleared).
